network_sequencer: RTL and testbench

//  Initiator side of the layer start/done handshake. Runs NUM_LAYERS layer controllers in order.

---
 rtl/network_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_network_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_sequencer.sv
// Sequences NUM_LAYERS layer controllers through start/done handshakes, muxes the active
// layer's weight-ROM address onto the shared ROM, then scans the final-layer outputs for the argmax.
module network_sequencer #(
   parameter int NUM_LAYERS  = 3,
   parameter int ADDR_W      = 15,
   parameter int NUM_CLASSES = 5,
   parameter int TIMEOUT     = 65535
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           run,
   output logic [NUM_LAYERS-1:0]          layer_start,
   input  logic [NUM_LAYERS-1:0]          layer_done,
   input  logic [NUM_LAYERS*ADDR_W-1:0]   layer_addr,
   output logic [ADDR_W-1:0]              rom_addr,
   input  logic [NUM_CLASSES*32-1:0]      class_in,
   output logic [$clog2(NUM_LAYERS):0]    active_layer,
   output logic                           busy,
   output logic                           result_valid,
   output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
   output logic [31:0]                    class_score,
   output logic                           error
);
   localparam int K_W   = $clog2(NUM_LAYERS) + 1;
   localparam int IDX_W = $clog2(NUM_CLASSES);
   localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_LAYERS - 1);
   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(NUM_CLASSES - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_RELEASE, S_ARGMAX, S_RESULT, S_ERR} state_t;

   state_t                 state_reg, state_next;
   logic [K_W-1:0]         k_reg, k_next;
   logic [WD_W-1:0]        wdog_reg, wdog_next;
   logic [IDX_W-1:0]       cnt_reg, cnt_next;
   logic [IDX_W-1:0]       bidx_reg, bidx_next;
   logic [IDX_W-1:0]       class_idx_reg, class_idx_next;
   logic signed [31:0]     best_reg, best_next;
   logic [31:0]            class_score_reg, class_score_next;
   logic [NUM_LAYERS-1:0]  layer_start_reg, layer_start_next;

   logic [ADDR_W-1:0]      addr_arr [NUM_LAYERS];
   logic signed [31:0]     class_arr [NUM_CLASSES];
   logic [ADDR_W-1:0]      sel_addr;
   logic                   sel_done;
   logic signed [31:0]     sel_class;
   logic                   upd;
   logic                   wdog_hit;
   logic                   in_layer;

   generate
      for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_addr
         assign addr_arr[gi] = layer_addr[gi*ADDR_W +: ADDR_W];
      end
      for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
         assign class_arr[gi] = class_in[gi*32 +: 32];
      end
   endgenerate

   // Only the active layer's done and address matter; other layers are ignored.
   always_comb begin
      sel_addr = '0;
      sel_done = 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (k_reg == K_W'(i)) begin
            sel_addr = addr_arr[i];
            sel_done = layer_done[i];
         end
      end
   end

   always_comb begin
      sel_class = class_arr[0];
      for (int i = 1; i < NUM_CLASSES; i++) begin
         if (cnt_reg == IDX_W'(i)) sel_class = class_arr[i];
      end
   end

   // Strict greater-than so ties keep the lower index.
   assign upd      = sel_class > best_reg;
   assign wdog_hit = (TIMEOUT != 0) && (wdog_reg == WD_LAST);

   always_comb begin
      state_next       = state_reg;
      k_next           = k_reg;
      wdog_next        = wdog_reg;
      cnt_next         = cnt_reg;
      best_next        = best_reg;
      bidx_next        = bidx_reg;
      class_idx_next   = class_idx_reg;
      class_score_next = class_score_reg;
      case (state_reg)
         S_IDLE: begin
            if (run) begin
               state_next = S_START;
               k_next     = '0;
               wdog_next  = '0;
            end
         end
         S_START: begin
            if (sel_done) begin
               state_next = S_RELEASE;
               wdog_next  = '0;
            end else if (wdog_hit) begin
               state_next = S_ERR;
            end else begin
               wdog_next = wdog_reg + WD_W'(1);
            end
         end
         S_RELEASE: begin
            if (!sel_done) begin
               wdog_next = '0;
               if (k_reg == K_LAST) begin
                  state_next = S_ARGMAX;
                  best_next  = class_arr[0];
                  bidx_next  = '0;
                  cnt_next   = IDX_W'(1);
               end else begin
                  state_next = S_START;
                  k_next     = k_reg + K_W'(1);
               end
            end else if (wdog_hit) begin
               state_next = S_ERR;
            end else begin
               wdog_next = wdog_reg + WD_W'(1);
            end
         end
         S_ARGMAX: begin
            if (upd) begin
               best_next = sel_class;
               bidx_next = cnt_reg;
            end
            if (cnt_reg == CNT_LAST) begin
               state_next       = S_RESULT;
               class_idx_next   = bidx_next;
               class_score_next = best_next;
            end else begin
               cnt_next = cnt_reg + IDX_W'(1);
            end
         end
         S_RESULT, S_ERR: begin
            if (!run) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      layer_start_next = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         layer_start_next[i] = (state_next == S_START) && (k_next == K_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         k_reg           <= '0;
         wdog_reg        <= '0;
         cnt_reg         <= '0;
         best_reg        <= '0;
         bidx_reg        <= '0;
         class_idx_reg   <= '0;
         class_score_reg <= '0;
         layer_start_reg <= '0;
      end else begin
         state_reg       <= state_next;
         k_reg           <= k_next;
         wdog_reg        <= wdog_next;
         cnt_reg         <= cnt_next;
         best_reg        <= best_next;
         bidx_reg        <= bidx_next;
         class_idx_reg   <= class_idx_next;
         class_score_reg <= class_score_next;
         layer_start_reg <= layer_start_next;
      end
   end

   // The ROM path stays combinational so layers see no extra read latency.
   assign in_layer     = (state_reg == S_START) || (state_reg == S_RELEASE);
   assign rom_addr     = in_layer ? sel_addr : '0;
   assign active_layer = in_layer ? k_reg : '0;
   assign layer_start  = layer_start_reg;
   assign busy         = state_reg != S_IDLE;
   assign result_valid = state_reg == S_RESULT;
   assign error        = state_reg == S_ERR;
   assign class_idx    = class_idx_reg;
   assign class_score  = class_score_reg;

endmodule

// File: tb/tb_network_sequencer.sv
// Randomized bench for network_sequencer: a cycle-level reference model of the handshake rules,
// plus directed runs for ordering, argmax, ROM mux, watchdog, stray done and mid-run reset.
module tb_network_sequencer;
   localparam int NL  = 3;
   localparam int AW  = 15;
   localparam int NC  = 5;
   localparam int TO  = 16;
   localparam int CW  = $clog2(NL) + 1;
   localparam int IW  = $clog2(NC);
   localparam int P_IDLE = 0, P_START = 1, P_RELEASE = 2, P_ARGMAX = 3, P_RESULT = 4, P_ERR = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            run = 1'b0;
   logic [NL-1:0]   layer_start;
   logic [NL-1:0]   layer_done = '0;
   logic [NL*AW-1:0] layer_addr = '0;
   logic [AW-1:0]   rom_addr;
   logic [NC*32-1:0] class_in = '0;
   logic [CW-1:0]   active_layer;
   logic            busy, result_valid, error;
   logic [IW-1:0]   class_idx;
   logic [31:0]     class_score;

   // second instance with an 8-cycle watchdog, driven by directed stimulus only
   logic            run_w = 1'b0;
   logic [NL-1:0]   layer_start_w;
   logic [NL-1:0]   layer_done_w = '0;
   logic [NL*AW-1:0] layer_addr_w = '0;
   logic [AW-1:0]   rom_addr_w;
   logic [NC*32-1:0] class_in_w = '0;
   logic [CW-1:0]   active_layer_w;
   logic            busy_w, result_valid_w, error_w;
   logic [IW-1:0]   class_idx_w;
   logic [31:0]     class_score_w;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   network_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .NUM_CLASSES(NC), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .run(run), .layer_start(layer_start), .layer_done(layer_done),
      .layer_addr(layer_addr), .rom_addr(rom_addr), .class_in(class_in), .active_layer(active_layer),
      .busy(busy), .result_valid(result_valid), .class_idx(class_idx), .class_score(class_score),
      .error(error));

   network_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .NUM_CLASSES(NC), .TIMEOUT(8)) dut_w (
      .clk(clk), .reset(reset), .run(run_w), .layer_start(layer_start_w), .layer_done(layer_done_w),
      .layer_addr(layer_addr_w), .rom_addr(rom_addr_w), .class_in(class_in_w),
      .active_layer(active_layer_w), .busy(busy_w), .result_valid(result_valid_w),
      .class_idx(class_idx_w), .class_score(class_score_w), .error(error_w));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic bound_expired(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   int m_phase = P_IDLE;
   int m_k = 0;
   int m_wait = 0;
   int m_left = 0;
   int m_idx = 0;
   logic [31:0] m_score = '0;
   int m_pend_idx = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = P_IDLE;
         m_k = 0;
         m_wait = 0;
         m_idx = 0;
         m_score = '0;
      end else begin
         case (m_phase)
            P_IDLE: if (run) begin m_phase = P_START; m_k = 0; m_wait = 0; end
            P_START, P_RELEASE: begin
               if ((m_phase == P_START) == (layer_done[m_k] == 1'b1)) begin
                  m_wait = 0;
                  if (m_phase == P_START) m_phase = P_RELEASE;
                  else if (m_k == NL - 1) begin
                     m_pend_idx = 0;
                     for (int i = 1; i < NC; i++)
                        if ($signed(class_in[i*32 +: 32]) > $signed(class_in[m_pend_idx*32 +: 32]))
                           m_pend_idx = i;
                     m_left = NC - 1;
                     m_phase = P_ARGMAX;
                  end else begin
                     m_k++;
                     m_phase = P_START;
                  end
               end else begin
                  m_wait++;
                  if (m_wait >= TO) m_phase = P_ERR;
               end
            end
            P_ARGMAX: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = P_RESULT;
                  m_idx = m_pend_idx;
                  m_score = class_in[m_pend_idx*32 +: 32];
               end
            end
            default: if (!run) m_phase = P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin : cmp
         logic [NL-1:0] e_start;
         logic [AW-1:0] e_rom;
         int e_act;
         bit in_l;
         in_l = (m_phase == P_START) || (m_phase == P_RELEASE);
         e_start = '0;
         if (m_phase == P_START) e_start[m_k] = 1'b1;
         e_rom = in_l ? layer_addr[m_k*AW +: AW] : '0;
         e_act = in_l ? m_k : 0;
         check("layer_start", 64'(layer_start), 64'(e_start));
         check("rom_addr", 64'(rom_addr), 64'(e_rom));
         check("active_layer", 64'(active_layer), 64'(e_act));
         check("busy", 64'(busy), 64'(m_phase != P_IDLE));
         check("result_valid", 64'(result_valid), 64'(m_phase == P_RESULT));
         check("error", 64'(error), 64'(m_phase == P_ERR));
         check("class_idx", 64'(class_idx), 64'(m_idx));
         check("class_score", 64'(class_score), 64'(m_score));
      end
   end

   // ---------------- layer responders ----------------
   int dly_up[NL];
   int dly_dn[NL];
   int noise_mode = 0;
   logic [NL-1:0] real_done = '0;
   int up_cnt[NL];
   int dn_cnt[NL];

   always begin : responder
      logic [NL-1:0] noise;
      @(posedge clk);
      #1;
      for (int i = 0; i < NL; i++) begin
         if (layer_start[i]) begin
            dn_cnt[i] = 0;
            if (!real_done[i]) begin
               up_cnt[i]++;
               if (up_cnt[i] >= dly_up[i]) real_done[i] = 1'b1;
            end
         end else begin
            up_cnt[i] = 0;
            if (real_done[i]) begin
               dn_cnt[i]++;
               if (dn_cnt[i] >= dly_dn[i]) begin real_done[i] = 1'b0; dn_cnt[i] = 0; end
            end
         end
      end
      noise = '0;
      if (m_phase == P_START || m_phase == P_RELEASE)
         for (int i = 0; i < NL; i++)
            if (i != m_k)
               noise[i] = (noise_mode == 2) || (noise_mode == 1 && $urandom_range(0, 2) == 0);
      layer_done = real_done | noise;
   end

   task automatic set_delays(input int up, input int dn);
      for (int i = 0; i < NL; i++) begin dly_up[i] = up; dly_dn[i] = dn; end
   endtask

   task automatic settle();
      int n;
      run = 1'b0;
      for (n = 0; n < 100 && (busy || real_done != 0); n++) tick();
      if (n >= 100) bound_expired("settle");
   endtask

   task automatic wait_result(input string name);
      int n;
      for (n = 0; n < 400 && !result_valid && !error; n++) tick();
      if (n >= 400) bound_expired(name);
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish at %0t", $time);
      $fatal(1, "global timeout");
   end

   initial begin : main
      logic [NL-1:0] seen[$];
      logic [NL-1:0] prev_start;
      logic [AW-1:0] exp_addr[NL];
      int exp_order[NL];
      int n, am, cyc, drop_at, reset_at, pick;
      bit rel_last;

      set_delays(10, 1);
      tick(); chk_en = 1'b1; tick(); tick();
      // reset state
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_start", 64'(layer_start), 64'd0);
      check("rst_class_idx", 64'(class_idx), 64'd0);
      check("rst_error_w", 64'(error_w), 64'd0);
      reset = 1'b0;

      // nominal order, argmax with tie, ROM mux
      class_in[0*32 +: 32] = 32'd7;
      class_in[1*32 +: 32] = -32'sd3;
      class_in[2*32 +: 32] = 32'd42;
      class_in[3*32 +: 32] = 32'd42;
      class_in[4*32 +: 32] = 32'd5;
      exp_addr = '{15'h0100, 15'h0093, 15'h0010};
      exp_order = '{1, 2, 4};
      for (int i = 0; i < NL; i++) layer_addr[i*AW +: AW] = exp_addr[i];
      run = 1'b1;
      prev_start = '0; am = 0; rel_last = 1'b0;
      for (n = 0; n < 300 && !result_valid; n++) begin
         tick();
         if (layer_start != 0 && layer_start != prev_start) seen.push_back(layer_start);
         for (int i = 0; i < NL; i++)
            if (layer_start == NL'(1 << i)) check("rom_in_start", 64'(rom_addr), 64'(exp_addr[i]));
         if (active_layer == CW'(NL - 1) && layer_start == 0) rel_last = 1'b1;
         else if (rel_last && busy && !result_valid) am++;
         prev_start = layer_start;
      end
      if (n >= 300) bound_expired("nominal_result");
      check("order_len", 64'(seen.size()), 64'd3);
      for (int i = 0; i < NL; i++)
         if (i < seen.size()) check("order", 64'(seen[i]), 64'(exp_order[i]));
      check("argmax_cycles", 64'(am), 64'(NC - 1));
      check("argmax_idx", 64'(class_idx), 64'd2);
      check("argmax_score", 64'(class_score), 64'd42);
      check("rom_in_result", 64'(rom_addr), 64'd0);
      run = 1'b0;
      tick();
      check("idle_after_result", 64'(busy), 64'd0);
      check("idx_held", 64'(class_idx), 64'd2);
      settle();
      $display("nominal run: class_idx=%0d class_score=%0d", class_idx, class_score);

      // stray done on every inactive layer, run dropped mid-layer-1
      noise_mode = 2;
      run = 1'b1;
      for (n = 0; n < 200 && active_layer != CW'(1); n++) tick();
      if (n >= 200) bound_expired("stray_reach_l1");
      run = 1'b0;
      wait_result("stray_result");
      check("stray_result_valid", 64'(result_valid), 64'd1);
      check("stray_idx", 64'(class_idx), 64'd2);
      tick();
      check("stray_idle_next", 64'(busy), 64'd0);
      check("stray_rv_next", 64'(result_valid), 64'd0);
      noise_mode = 0;
      settle();
      $display("stray run: class_idx=%0d", class_idx);

      // reset during START of layer 1
      run = 1'b1;
      for (n = 0; n < 200 && layer_start != NL'(2); n++) tick();
      if (n >= 200) bound_expired("reset_reach_l1");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_start", 64'(layer_start), 64'd0);
      check("mid_rst_active", 64'(active_layer), 64'd0);
      check("mid_rst_rom", 64'(rom_addr), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_idx", 64'(class_idx), 64'd0);
      check("mid_rst_score", 64'(class_score), 64'd0);
      for (n = 0; n < 50 && layer_start == 0; n++) tick();
      check("restart_layer0", 64'(layer_start), 64'd1);
      wait_result("restart_result");
      check("restart_idx", 64'(class_idx), 64'd2);
      settle();
      $display("reset run: class_idx=%0d", class_idx);

      // watchdog on the 8-cycle instance: layer 1 never answers
      run_w = 1'b1;
      for (n = 0; n < 50; n++) begin
         tick();
         if (layer_start_w == NL'(2)) break;
         layer_done_w[0] = layer_start_w[0];
      end
      am = 1;
      for (n = 0; n < 50 && layer_start_w == NL'(2); n++) begin
         tick();
         if (layer_start_w == NL'(2)) am++;
      end
      check("wd_wait_cycles", 64'(am), 64'd8);
      check("wd_error", 64'(error_w), 64'd1);
      check("wd_start_off", 64'(layer_start_w), 64'd0);
      run_w = 1'b0;
      tick();
      check("wd_error_clear", 64'(error_w), 64'd0);
      check("wd_idle", 64'(busy_w), 64'd0);
      $display("watchdog run: waited %0d cycles", am);

      // randomized runs
      for (int r = 0; r < 60; r++) begin
         for (int i = 0; i < NC; i++)
            class_in[i*32 +: 32] = $urandom_range(0, 1) ? 32'($urandom_range(0, 6)) - 32'd3 : $urandom;
         for (int i = 0; i < NL; i++) begin
            layer_addr[i*AW +: AW] = AW'($urandom);
            pick = $urandom_range(0, 31);
            dly_up[i] = (pick <= 26) ? 1 + pick % 12 : (pick == 27) ? 15 : (pick == 28) ? 16
                      : (pick == 29) ? 17 : 30;
            pick = $urandom_range(0, 15);
            dly_dn[i] = (pick < 13) ? 1 + pick % 3 : (pick == 13) ? 16 : (pick == 14) ? 17 : 2;
         end
         noise_mode = $urandom_range(0, 2);
         drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
         reset_at = (drop_at == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : 0;
         run = 1'b1;
         cyc = 0;
         for (n = 0; n < 400 && !result_valid && !error; n++) begin
            tick();
            cyc++;
            if (cyc == drop_at) run = 1'b0;
            if (cyc == reset_at) begin reset = 1'b1; tick(); reset = 1'b0; end
         end
         if (n >= 400) bound_expired("random_result");
         $display("run %0d: result_valid=%0b error=%0b class_idx=%0d class_score=%0d",
                  r, result_valid, error, class_idx, class_score);
         for (int h = $urandom_range(0, 2); h > 0 && result_valid; h--) tick();
         noise_mode = 0;
         settle();
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
